// File: rtl/rag_tok_pkg.sv
// Token ID constants and vocabulary entry layout shared by the tokenizer and detokenizer.
// UNK_MARK_ENTRY is only referenced when DETOK_UNK_MARK_EN is defined.
package rag_tok_pkg;

    localparam logic [31:0] TOK_PAD = 32'd0;
    localparam logic [31:0] TOK_UNK = 32'd100;
    localparam logic [31:0] TOK_CLS = 32'd101;
    localparam logic [31:0] TOK_SEP = 32'd102;

    localparam logic [31:0] VOCAB_BASE_DEFAULT = 32'h2000;

    // Entry layout: byte 0 = len, bytes 1..len = characters; "##" prefix marks a continuation.
    localparam int         ENTRY_LEN_IDX   = 0;
    localparam int         ENTRY_CHAR_IDX  = 1;
    localparam int         ENTRY_CONT_SKIP = 3;
    localparam logic [7:0] CONT_MARK       = 8'h23;
    localparam logic [7:0] SPACE_CHAR      = 8'h20;

    // Synthetic entry for "[UNK]" in the same layout, byte 1 in bits [15:8].
    localparam logic [47:0] UNK_MARK_ENTRY = {8'h5D, 8'h4B, 8'h4E, 8'h55, 8'h5B, 8'd5};

    function automatic logic is_skip_id(input logic [31:0] id);
        return (id == TOK_PAD) || (id == TOK_CLS) || (id == TOK_SEP);
    endfunction

endpackage

// File: rtl/detokenizer_if.sv
// Bundle of the detokenizer control, token, text and vocabulary memory signals.
// Streams: a beat transfers on a clock edge where valid && ready; valid-side data holds until then.
interface detokenizer_if #(
    parameter int BUS_WIDTH = 512
);
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [31:0]          tok_id;
    logic                 tok_valid;
    logic                 tok_last;
    logic                 tok_ready;
    logic [7:0]           text_byte;
    logic                 text_valid;
    logic                 text_ready;
    logic                 mem_rd_en;
    logic [31:0]          mem_rd_addr;
    logic [BUS_WIDTH-1:0] mem_rd_data;
    logic                 mem_rd_valid;

    modport slave (
        input  start, tok_id, tok_valid, tok_last, text_ready, mem_rd_data, mem_rd_valid,
        output busy, done, tok_ready, text_byte, text_valid, mem_rd_en, mem_rd_addr
    );

    modport master (
        output start, tok_id, tok_valid, tok_last, text_ready, mem_rd_data, mem_rd_valid,
        input  busy, done, tok_ready, text_byte, text_valid, mem_rd_en, mem_rd_addr
    );

endinterface

// File: rtl/detokenizer_vocab_entry_decode.sv
// Combinational view of one vocabulary entry: clamped length, continuation flag, byte k.
module vocab_entry_decode
    import rag_tok_pkg::*;
#(
    parameter  int BUS_WIDTH = 512,
    localparam int BYTES     = BUS_WIDTH / 8,
    localparam int KW        = $clog2(BYTES)
) (
    input  logic [BUS_WIDTH-1:0] entry_i,
    input  logic [KW-1:0]        k_i,
    output logic [KW-1:0]        len_o,
    output logic                 cont_o,
    output logic [7:0]           byte_o
);

    logic [7:0] len_raw;

    always_comb begin
        len_raw = entry_i[ENTRY_LEN_IDX*8 +: 8];
        len_o   = (len_raw > 8'(BYTES - 1)) ? KW'(BYTES - 1) : len_raw[KW-1:0];
        cont_o  = (entry_i[ENTRY_CHAR_IDX*8 +: 8] == CONT_MARK) &&
                  (entry_i[(ENTRY_CHAR_IDX+1)*8 +: 8] == CONT_MARK);
        byte_o  = entry_i[{k_i, 3'b000} +: 8];
    end

endmodule

// File: rtl/detokenizer.sv
// WordPiece token IDs in, reconstructed text bytes out, one vocabulary read per printable token.
// Optional: DETOK_UNK_MARK_EN emits literal "[UNK]" for out-of-range IDs instead of fetching UNK.
module detokenizer
    import rag_tok_pkg::*;
#(
    parameter int unsigned VOCAB_SIZE = 30522,
    parameter int          BUS_WIDTH  = 512,
    parameter logic [31:0] VOCAB_BASE = VOCAB_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    detokenizer_if.slave      bus,
    output logic [2:0]        dbg_state_o
);

    localparam int BYTES = BUS_WIDTH / 8;
    localparam int KW    = $clog2(BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_FETCH, S_WAIT, S_SPACE, S_CHARS, S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          id_q, id_d;
    logic                 last_q, last_d;
    logic [BUS_WIDTH-1:0] entry_q, entry_d;
    logic [KW-1:0]        k_q, k_d;
    logic                 word_started_q, word_started_d;

    logic [BUS_WIDTH-1:0] dec_entry;
    logic [KW-1:0]        dec_len;
    logic                 dec_cont;
    logic [7:0]           dec_byte;

    // The response is decoded in the same cycle it arrives; afterwards the latched copy is used.
    assign dec_entry = (state_q == S_WAIT) ? bus.mem_rd_data : entry_q;

    vocab_entry_decode #(.BUS_WIDTH(BUS_WIDTH)) u_decode (
        .entry_i (dec_entry),
        .k_i     (k_q),
        .len_o   (dec_len),
        .cont_o  (dec_cont),
        .byte_o  (dec_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            id_q           <= '0;
            last_q         <= 1'b0;
            entry_q        <= '0;
            k_q            <= '0;
            word_started_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            id_q           <= id_d;
            last_q         <= last_d;
            entry_q        <= entry_d;
            k_q            <= k_d;
            word_started_q <= word_started_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        id_d           = id_q;
        last_d         = last_q;
        entry_d        = entry_q;
        k_d            = k_q;
        word_started_d = word_started_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    word_started_d = 1'b0;
                    state_d        = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (bus.tok_valid) begin
                    last_d = bus.tok_last;
                    if (is_skip_id(bus.tok_id)) begin
                        state_d = bus.tok_last ? S_DONE : S_ACCEPT;
                    end else if (bus.tok_id >= VOCAB_SIZE) begin
`ifdef DETOK_UNK_MARK_EN
                        entry_d = BUS_WIDTH'(UNK_MARK_ENTRY);
                        k_d     = KW'(ENTRY_CHAR_IDX);
                        state_d = word_started_q ? S_SPACE : S_CHARS;
`else
                        id_d    = TOK_UNK;
                        state_d = S_FETCH;
`endif
                    end else begin
                        id_d    = bus.tok_id;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.mem_rd_valid) begin
                    entry_d = bus.mem_rd_data;
                    k_d     = dec_cont ? KW'(ENTRY_CONT_SKIP) : KW'(ENTRY_CHAR_IDX);
                    if (k_d > dec_len) begin
                        state_d = last_q ? S_DONE : S_ACCEPT;
                    end else if (word_started_q && !dec_cont) begin
                        state_d = S_SPACE;
                    end else begin
                        state_d = S_CHARS;
                    end
                end
            end
            S_SPACE: begin
                if (bus.text_ready) state_d = S_CHARS;
            end
            S_CHARS: begin
                if (bus.text_ready) begin
                    k_d            = k_q + 1'b1;
                    word_started_d = 1'b1;
                    if (k_q == dec_len) state_d = last_q ? S_DONE : S_ACCEPT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.tok_ready   = (state_q == S_ACCEPT);
    assign bus.text_valid  = (state_q == S_SPACE) || (state_q == S_CHARS);
    assign bus.text_byte   = (state_q == S_SPACE) ? SPACE_CHAR :
                             (state_q == S_CHARS) ? dec_byte : 8'h00;
    assign bus.mem_rd_en   = (state_q == S_FETCH);
    assign bus.mem_rd_addr = (state_q == S_FETCH) ? (VOCAB_BASE + id_q * 32'(BYTES)) : 32'h0;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_detokenizer.sv
// Directed bench for detokenizer: memory responder, text collector and per-scenario tasks.
module tb_detokenizer;
    import rag_tok_pkg::*;

    localparam int BUS_WIDTH = 512;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;

    detokenizer_if #(.BUS_WIDTH(BUS_WIDTH)) bus ();

    detokenizer #(
        .VOCAB_SIZE (30522),
        .BUS_WIDTH  (BUS_WIDTH),
        .VOCAB_BASE (32'h2000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rd_count = 0;
    int          done_count = 0;
    int          done_cyc = 0;
    int          last_byte_cyc = 0;
    int          pend_cnt = 0;
    int          mem_lat = 1;
    int          rdy_mode = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] pend_addr = '0;
    bit          inject_stale = 1'b0;
    bit          stall_prev = 1'b0;
    logic [7:0]  prev_byte = '0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int          byte_cyc_q[$];

    function automatic logic [BUS_WIDTH-1:0] str_entry(input string s);
        logic [BUS_WIDTH-1:0] e;
        e = '0;
        e[7:0] = 8'(s.len());
        for (int i = 0; i < s.len(); i++) e[(i+1)*8 +: 8] = s[i];
        return e;
    endfunction

    function automatic logic [BUS_WIDTH-1:0] vocab(input logic [31:0] addr);
        logic [BUS_WIDTH-1:0] e;
        int id;
        e  = '0;
        id = int'((addr - 32'h2000) >> 6);
        case (id)
            2054: e = str_entry("what");
            2003: e = str_entry("is");
            1044: e = str_entry("##s");
            600:  e = str_entry("##");
            100:  e = str_entry("[UNK]");
            500: begin
                e[7:0] = 8'd80;
                for (int i = 1; i < 64; i++) e[i*8 +: 8] = 8'(8'h30 + i);
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    // Inputs change 1 time unit after the rising edge.
    always @(posedge clk) begin
        #1;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
        if (inject_stale) begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = vocab(32'h2000 + 32'd2054 * 32'd64);
            inject_stale     = 1'b0;
        end else if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                bus.mem_rd_valid = 1'b1;
                bus.mem_rd_data  = vocab(pend_addr);
            end
        end
        case (rdy_mode)
            0:       bus.text_ready = 1'b1;
            1:       bus.text_ready = ~bus.text_ready;
            default: bus.text_ready = 1'b0;
        endcase
    end

    // Outputs observed on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (stall_prev) begin
            checks++;
            if (bus.text_valid !== 1'b1 || bus.text_byte !== prev_byte) begin
                failures++;
                $display("FAIL stall_hold valid=%b byte=%h required_byte=%h", bus.text_valid, bus.text_byte, prev_byte);
            end
        end
        stall_prev = (bus.text_valid === 1'b1) && (bus.text_ready === 1'b0) && (rst === 1'b0);
        prev_byte  = bus.text_byte;
        if (bus.text_valid === 1'b1 && bus.text_ready === 1'b1) begin
            got_q.push_back(bus.text_byte);
            byte_cyc_q.push_back(cyc);
            last_byte_cyc = cyc;
        end
        if (bus.done === 1'b1) begin
            done_count++;
            done_cyc = cyc;
        end
        if (bus.mem_rd_en === 1'b1) begin
            checks++;
            if (pend_cnt != 0) begin
                failures++;
                $display("FAIL single_outstanding pending=%0d required=0", pend_cnt);
            end
            rd_count++;
            last_addr = bus.mem_rd_addr;
            pend_addr = bus.mem_rd_addr;
            pend_cnt  = mem_lat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        got_q.delete();
        exp_q.delete();
        byte_cyc_q.delete();
        rd_count   = 0;
        done_count = 0;
    endtask

    task automatic push_exp(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_tok(input logic [31:0] id, input logic last);
        int n;
        n = 0;
        bus.tok_id    = id;
        bus.tok_last  = last;
        bus.tok_valid = 1'b1;
        @(negedge clk);
        while (bus.tok_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (bus.tok_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL tok_handshake_timeout id=%0d ready=%b required=1", id, bus.tok_ready);
        end
        tick();
        bus.tok_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_count == 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (3) tick();
        checks++;
        if (done_count != 1) begin
            failures++;
            $display("FAIL done_pulses got=%0d required=1", done_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.tok_ready, bus.text_valid, bus.mem_rd_en,
             bus.text_byte, bus.mem_rd_addr, dbg_state} !== '0) begin
            failures++;
            $display("FAIL reset_outputs busy=%b done=%b rdy=%b tv=%b rd=%b byte=%h addr=%h st=%0d required=all_zero",
                     bus.busy, bus.done, bus.tok_ready, bus.text_valid, bus.mem_rd_en, bus.text_byte, bus.mem_rd_addr, dbg_state);
        end
        tick();
        rst = 1'b0;
        clear_sb();
        bus.tok_id    = 32'd2054;
        bus.tok_last  = 1'b1;
        bus.tok_valid = 1'b1;
        repeat (4) tick();
        bus.tok_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (rd_count != 0 || got_q.size() != 0 || bus.busy !== 1'b0 || done_count != 0) begin
            failures++;
            $display("FAIL idle_tok_ignored reads=%0d bytes=%0d busy=%b done=%0d required=0/0/0/0",
                     rd_count, got_q.size(), bus.busy, done_count);
        end
    endtask

    task automatic test_address();
        clear_sb();
        mem_lat  = 1;
        rdy_mode = 0;
        push_exp("what");
        pulse_start();
        send_tok(TOK_CLS, 1'b0);
        pulse_start();
        send_tok(32'd2054, 1'b0);
        send_tok(TOK_SEP, 1'b1);
        wait_done(100);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL addr_len got=%0d required=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL addr_byte[%0d] got=%h required=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (rd_count != 1) begin
            failures++;
            $display("FAIL addr_reads got=%0d required=1", rd_count);
        end
        checks++;
        if (last_addr !== 32'h0002_2180) begin
            failures++;
            $display("FAIL addr_value got=%h required=00022180", last_addr);
        end
        checks++;
        if (byte_cyc_q.size() != 4 || byte_cyc_q[3] - byte_cyc_q[0] != 3) begin
            failures++;
            $display("FAIL addr_byte_rate bytes=%0d span=%0d required=4/3", byte_cyc_q.size(), byte_cyc_q[3] - byte_cyc_q[0]);
        end
    endtask

    task automatic test_spacing();
        clear_sb();
        mem_lat  = 1;
        rdy_mode = 0;
        push_exp("what iss");
        pulse_start();
        send_tok(32'd2054, 1'b0);
        send_tok(32'd2003, 1'b0);
        send_tok(32'd1044, 1'b1);
        wait_done(200);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL space_len got=%0d required=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL space_byte[%0d] got=%h required=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (rd_count != 3) begin
            failures++;
            $display("FAIL space_reads got=%0d required=3", rd_count);
        end
        checks++;
        if (done_cyc != last_byte_cyc + 1) begin
            failures++;
            $display("FAIL space_done_timing got=%0d required=%0d", done_cyc, last_byte_cyc + 1);
        end
    endtask

    task automatic test_backpressure();
        clear_sb();
        mem_lat  = 7;
        rdy_mode = 1;
        push_exp("what iss");
        pulse_start();
        send_tok(32'd2054, 1'b0);
        send_tok(32'd2003, 1'b0);
        send_tok(32'd1044, 1'b1);
        wait_done(400);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL bp_len got=%0d required=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL bp_byte[%0d] got=%h required=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (rd_count != 3) begin
            failures++;
            $display("FAIL bp_reads got=%0d required=3", rd_count);
        end
        rdy_mode = 0;
        mem_lat  = 1;
        repeat (2) tick();
    endtask

    task automatic test_degenerate();
        clear_sb();
        for (int i = 1; i < 64; i++) exp_q.push_back(8'(8'h30 + i));
        pulse_start();
        send_tok(32'd500, 1'b1);
        wait_done(200);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL clamp_len got=%0d required=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL clamp_byte[%0d] got=%h required=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        clear_sb();
        push_exp("whats");
        pulse_start();
        send_tok(32'd2054, 1'b0);
        send_tok(32'd600, 1'b0);
        send_tok(32'd1044, 1'b1);
        wait_done(200);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL empty_cont_len got=%0d required=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL empty_cont_byte[%0d] got=%h required=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (rd_count != 3) begin
            failures++;
            $display("FAIL empty_cont_reads got=%0d required=3", rd_count);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_sb();
        rdy_mode = 2;
        pulse_start();
        send_tok(32'd2054, 1'b1);
        n = 0;
        @(negedge clk);
        while (bus.text_valid !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (bus.text_valid !== 1'b1 || bus.text_byte !== 8'h77) begin
            failures++;
            $display("FAIL mid_first_char valid=%b byte=%h required=1/77", bus.text_valid, bus.text_byte);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.tok_ready, bus.text_valid, bus.mem_rd_en,
             bus.text_byte, bus.mem_rd_addr, dbg_state} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs busy=%b tv=%b byte=%h st=%0d required=all_zero",
                     bus.busy, bus.text_valid, bus.text_byte, dbg_state);
        end
        rdy_mode     = 0;
        inject_stale = 1'b1;
        repeat (5) tick();
        checks++;
        if (got_q.size() != 0 || bus.busy !== 1'b0 || dbg_state !== 3'd0 || done_count != 0) begin
            failures++;
            $display("FAIL stale_response bytes=%0d busy=%b st=%0d done=%0d required=0/0/0/0",
                     got_q.size(), bus.busy, dbg_state, done_count);
        end
    endtask

    task automatic test_empty();
        clear_sb();
        pulse_start();
        send_tok(TOK_PAD, 1'b1);
        wait_done(50);
        checks++;
        if (got_q.size() != 0 || rd_count != 0) begin
            failures++;
            $display("FAIL empty_seq bytes=%0d reads=%0d required=0/0", got_q.size(), rd_count);
        end
    endtask

    task automatic test_oor();
        clear_sb();
        push_exp("what [UNK]");
        pulse_start();
        send_tok(32'd2054, 1'b0);
        send_tok(32'd40000, 1'b1);
        wait_done(200);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL oor_len got=%0d required=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL oor_byte[%0d] got=%h required=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
`ifdef DETOK_UNK_MARK_EN
        checks++;
        if (rd_count != 1) begin
            failures++;
            $display("FAIL oor_reads got=%0d required=1", rd_count);
        end
`else
        checks++;
        if (rd_count != 2 || last_addr !== 32'h0000_3900) begin
            failures++;
            $display("FAIL oor_fetch reads=%0d addr=%h required=2/00003900", rd_count, last_addr);
        end
`endif
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.tok_valid    = 1'b0;
        bus.tok_id       = '0;
        bus.tok_last     = 1'b0;
        bus.text_ready   = 1'b1;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
        test_reset();
        test_address();
        test_spacing();
        test_backpressure();
        test_degenerate();
        test_reset_mid();
        test_empty();
        test_oor();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
